// File: rtl/fetch_stage.sv
// IF stage and IF/ID register of the 16-bit core.
// Owns the PC; applies stall, ID-resolved redirect and halt-on-HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pp2_q, pp2_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_plus2;
  logic        is_hlt;
  logic        unused_tgt_lsb;

  assign pc_plus2       = pc_q + 16'd2;
  assign is_hlt         = (imem_data[15:12] == 4'hF);
  assign unused_tgt_lsb = branch_target[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp2_d   = pp2_q;
    valid_d = valid_q;
    unique case (state_q)
      RUN: begin
        if (!stall) begin
          if (branch_taken) begin
            // Wrong-path word (even HLT) is squashed.
            pc_d    = {branch_target[15:1], 1'b0};
            instr_d = BUBBLE_INSTR;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_data;
            pp2_d   = pc_plus2;
            valid_d = 1'b1;
            if (is_hlt) state_d = HALTED;
            else        pc_d    = pc_plus2;
          end
        end
      end
      HALTED: begin
        if (!stall) begin
          instr_d = BUBBLE_INSTR;
          valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= BUBBLE_INSTR;
      pp2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp2_q   <= pp2_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus2 = pp2_q;
  assign if_id_valid    = valid_q;
  assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Linear steps with immediate-assertion checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_stage #(
    .RESET_PC    (16'h0000),
    .BUBBLE_INSTR(16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [15:0] addr,
                          input logic [15:0] instr,
                          input logic [15:0] pp2,
                          input logic        vld,
                          input logic        hlt);
    check({tag, ".addr"},  imem_addr,      addr);
    check({tag, ".instr"}, if_id_instr,    instr);
    check({tag, ".pp2"},   if_id_pc_plus2, pp2);
    check({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, vld});
    check({tag, ".halt"},  {15'd0, halted},      {15'd0, hlt});
  endtask

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    imem_data     = 16'h0000;
    step();
    step();
    chk_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    imem_data = 16'h1123;
    step();
    chk_ifid("seq0", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0);
    imem_data = 16'h2456;
    step();
    chk_ifid("seq1", 16'h0004, 16'h2456, 16'h0004, 1'b1, 1'b0);
    imem_data = 16'h0789;
    step();
    chk_ifid("seq2", 16'h0006, 16'h0789, 16'h0006, 1'b1, 1'b0);
    imem_data = 16'h3000;
    step();
    chk_ifid("seq3", 16'h0008, 16'h3000, 16'h0008, 1'b1, 1'b0);

    // Stall with a pending branch: nothing moves.
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    imem_data     = 16'h4000;
    step();
    chk_ifid("stall1", 16'h0008, 16'h3000, 16'h0008, 1'b1, 1'b0);
    step();
    chk_ifid("stall2", 16'h0008, 16'h3000, 16'h0008, 1'b1, 1'b0);
    stall = 1'b0;
    step();
    chk_ifid("br20", 16'h0020, 16'h0000, 16'h0008, 1'b0, 1'b0);

    branch_target = 16'h0010;
    step();
    check("br10.addr", imem_addr, 16'h0010);
    branch_target = 16'h0041;
    step();
    chk_ifid("br41", 16'h0040, 16'h0000, 16'h0008, 1'b0, 1'b0);
    branch_taken = 1'b0;
    imem_data    = 16'h5555;
    step();
    chk_ifid("at40", 16'h0042, 16'h5555, 16'h0042, 1'b1, 1'b0);

    // Halt at 0x000C.
    branch_taken  = 1'b1;
    branch_target = 16'h000C;
    step();
    check("brC.addr", imem_addr, 16'h000C);
    branch_taken = 1'b0;
    imem_data    = 16'hF000;
    step();
    chk_ifid("hlt", 16'h000C, 16'hF000, 16'h000E, 1'b1, 1'b1);
    imem_data = 16'h1111;
    step();
    chk_ifid("hlt+1", 16'h000C, 16'h0000, 16'h000E, 1'b0, 1'b1);
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    step();
    chk_ifid("hltbr", 16'h000C, 16'h0000, 16'h000E, 1'b0, 1'b1);
    branch_taken = 1'b0;
    rst          = 1'b1;
    step();
    chk_ifid("hltrst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // HLT on the wrong path is squashed by the redirect.
    imem_data     = 16'hF000;
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    step();
    chk_ifid("hltsq", 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);
    imem_data = 16'h6000;
    branch_taken = 1'b0;
    step();
    chk_ifid("hltsq+1", 16'h0102, 16'h6000, 16'h0102, 1'b1, 1'b0);

    // Wrap-around; target bit 0 dropped.
    branch_taken  = 1'b1;
    branch_target = 16'hFFFF;
    step();
    check("brFFFE.addr", imem_addr, 16'hFFFE);
    branch_taken = 1'b0;
    imem_data    = 16'h1234;
    step();
    chk_ifid("wrap", 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage and IF/ID pipeline register of the five-stage 16-bit core. It owns the PC, drives the instruction-memory address, and captures the fetched word plus PC+2 into IF/ID for the decode stage. It applies the branch redirect resolved in ID, stall from the hazard unit, and halt detection.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
BUBBLE_INSTR, 16'h0000, instruction word placed in IF/ID when it holds a bubble (if_id_valid=0)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
branch_taken  input  1  ID stage resolved a taken B/BR this cycle
branch_target  input  16  redirect address from ID; bit 0 ignored
imem_addr  output  16  instruction-memory address (= PC, combinational)
imem_data  input  16  instruction word at imem_addr, same cycle
if_id_instr  output  16  registered instruction to decode; opcode in [15:12], CCC in [11:9]
if_id_pc_plus2  output  16  registered PC+2 of that instruction (PCS result / branch base)
if_id_valid  output  1  1 = real instruction; 0 = bubble
halted  output  1  fetch has stopped on HLT

Behaviour:
- Reset (rst=1 at an edge, overrides everything): PC<=RESET_PC, if_id_instr<=BUBBLE_INSTR, if_id_pc_plus2<=16'h0000, if_id_valid<=0, state<=RUN, halted=0. Reset mid-halt or mid-stall returns to RUN.
- imem_addr = PC at all times. PC+2 is mod 2^16 (16'hFFFE+2 = 16'h0000).
- States: RUN, HALTED. halted=1 only in HALTED.
- Per-edge priority in RUN, highest first: rst > stall > branch_taken > halt fetch > normal.
- stall=1: PC, IF/ID, and state all hold. A branch_taken asserted in the same cycle is ignored, because the branch itself is held in ID and re-asserts when it resolves.
- branch_taken=1, stall=0:
  - PC<={branch_target[15:1],1'b0}.
  - IF/ID <= bubble (instr=BUBBLE_INSTR, valid=0, pc_plus2 holds its old value).
  - The wrong-path word in IF is squashed, even if it is HLT. State stays RUN.
  - Branch penalty is one bubble.
- Halt fetch (imem_data[15:12]==4'hF, stall=0, branch_taken=0):
  - IF/ID <= {imem_data, PC+2, valid=1}, so HLT travels down the pipe.
  - PC holds. state<=HALTED.
- Normal: IF/ID <= {imem_data, PC+2, valid=1}; PC<=PC+2.
- HALTED:
  - PC holds.
  - Each unstalled edge loads a bubble into IF/ID.
  - stall still freezes IF/ID.
  - branch_taken is ignored: only HLT or younger can be in ID.
  - Leaves HALTED only on rst.
- Downstream contract: decode and later stages gate RegWrite, MemWrite, set_N/Z/V, Branch and Halt with if_id_valid. BUBBLE_INSTR carries no meaning on its own.
- No combinational path from stall or branch_taken to imem_addr. All outputs except imem_addr are registered.

Test Plan:
- Reset then 3 free cycles, imem returns 16'h1123, 16'h2456, 16'h0789 at 0,2,4 -> imem_addr 0,2,4,6; IF/ID shows each word with pc_plus2 2,4,6 and valid=1.
- At PC=16'h0010 assert branch_taken, branch_target=16'h0041 -> next imem_addr=16'h0040; IF/ID valid=0, instr=16'h0000; next cycle fetches from 16'h0040.
- Assert stall 2 cycles at PC=16'h0008 with branch_taken=1 in both -> PC stays 16'h0008, IF/ID unchanged, no redirect. Then stall=0, branch_taken=1, target 16'h0020 -> PC=16'h0020.
- imem returns 16'hF000 at PC=16'h000C -> IF/ID={16'hF000, 16'h000E, 1}, halted=1 next cycle. Following cycles: PC=16'h000C, valid=0. rst=1 -> PC=0, halted=0.
- HLT word fetched in the same cycle as branch_taken (target 16'h0100) -> no halt; PC=16'h0100, bubble in IF/ID.
- PC=16'hFFFE normal fetch -> if_id_pc_plus2=16'h0000, next PC=16'h0000.
